lcd_bus_rx: RTL

- Display-side responder for the 8-bit 8080-style write bus that the LCD driver produces (lcd_data, lcd_rs, lcd_wr), plus a generator for the lcd_fmark tearing signal.
- Decodes command and parameter bytes, tracks the CASET/RASET address window, and assembles RGB565 pixels from RAMWR data with x/y coordinates.
- Used as a synthesizable display model for on-FPGA loopback testing of the driver, and as a bus snooper exported to pmod.

---
 rtl/lcd_bus_pkg.sv | 37 +++
 rtl/lcd_bus_sync_edge.sv | 48 ++++
 rtl/lcd_bus_rx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_pkg
// Description : Opcodes, decoder states and window check for the LCD bus
//               responder.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_bus_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;
    localparam logic [7:0] CMD_RAMWRC = 8'h3C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CASET = 3'd1,
        RASET = 3'd2,
        RAMWR = 3'd3,
        OTHER = 3'd4
    } state_t;

    // True when the address window cannot be addressed on a w x h panel.
    function automatic logic win_bad(
        input logic [15:0] xs,
        input logic [15:0] xe,
        input logic [15:0] ys,
        input logic [15:0] ye,
        input logic [15:0] w,
        input logic [15:0] h
    );
        return (xs > xe) || (xe >= w) || (ys > ye) || (ye >= h);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_sync_edge
// Description : Synchronises the {wr, rs, data} bus and emits a registered
//               one-cycle event with rs/data on each rising edge of wr.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_rs,
    input  logic       i_wr,
    output logic       o_evt,
    output logic       o_rs,
    output logic [7:0] o_data
);

    // Bit 9 is wr, bit 8 is rs, bits 7:0 are data.
    logic [9:0] r_sync [STAGES];
    logic       r_wr_prev;

    // wr resets high so an idle-high bus never looks like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= 10'h200;
            end
            r_wr_prev <= 1'b1;
            o_evt     <= 1'b0;
            o_rs      <= 1'b0;
            o_data    <= 8'h00;
        end else begin
            r_sync[0] <= {i_wr, i_rs, i_data};
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_wr_prev <= r_sync[STAGES-1][9];
            o_evt     <= r_sync[STAGES-1][9] & ~r_wr_prev;
            o_rs      <= r_sync[STAGES-1][8];
            o_data    <= r_sync[STAGES-1][7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_rx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_rx
// Description : Display-side responder for an 8080-style 8-bit write bus:
//               command decode, CASET/RASET window, RGB565 pixels, fmark.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_rx
    import lcd_bus_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int WIDTH_PX     = 320,
    parameter int HEIGHT_PX    = 240,
    parameter int FMARK_PERIOD = 200000,
    parameter int FMARK_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  lcd_data,
    input  logic        lcd_rs,
    input  logic        lcd_wr,
    output logic        lcd_fmark,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        window_err
);

    localparam int          c_cnt_w = (FMARK_PERIOD > 1) ? $clog2(FMARK_PERIOD) : 1;
    localparam logic [15:0] c_w     = 16'(WIDTH_PX);
    localparam logic [15:0] c_h     = 16'(HEIGHT_PX);

    logic       w_evt;
    logic       w_rs;
    logic [7:0] w_data;
    logic       w_win_bad;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic          r_phase;
    logic [7:0]    r_hi;
    logic [15:0]   r_xs, r_xe, r_ys, r_ye;
    logic [15:0]   r_x, r_y;
    logic [c_cnt_w-1:0] r_fm_cnt;

    lcd_bus_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_data (lcd_data),
        .i_rs   (lcd_rs),
        .i_wr   (lcd_wr),
        .o_evt  (w_evt),
        .o_rs   (w_rs),
        .o_data (w_data)
    );

    assign w_win_bad = win_bad(r_xs, r_xe, r_ys, r_ye, c_w, c_h);

    // Tearing pulse: free-running, unaffected by bus traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fm_cnt  <= '0;
            lcd_fmark <= 1'b0;
        end else begin
            lcd_fmark <= (r_fm_cnt < c_cnt_w'(FMARK_WIDTH));
            if (r_fm_cnt == c_cnt_w'(FMARK_PERIOD - 1)) begin
                r_fm_cnt <= '0;
            end else begin
                r_fm_cnt <= r_fm_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_phase    <= 1'b0;
            r_hi       <= 8'h00;
            r_xs       <= 16'd0;
            r_xe       <= c_w - 16'd1;
            r_ys       <= 16'd0;
            r_ye       <= c_h - 16'd1;
            r_x        <= 16'd0;
            r_y        <= 16'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'h00;
            pix_valid  <= 1'b0;
            pix_data   <= 16'h0000;
            pix_x      <= 9'd0;
            pix_y      <= 9'd0;
            window_err <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            pix_valid <= 1'b0;
            if (w_evt && !w_rs) begin
                // Any command drops a half-received pixel.
                cmd_valid <= 1'b1;
                cmd_byte  <= w_data;
                r_idx     <= 3'd0;
                r_phase   <= 1'b0;
                case (w_data)
                    CMD_CASET:  r_state <= CASET;
                    CMD_RASET:  r_state <= RASET;
                    CMD_RAMWR: begin
                        r_state <= RAMWR;
                        r_x     <= r_xs;
                        r_y     <= r_ys;
                    end
                    CMD_RAMWRC: r_state <= RAMWR;
                    CMD_NOP:    r_state <= OTHER;
                    default:    r_state <= OTHER;
                endcase
            end else if (w_evt) begin
                case (r_state)
                    CASET: begin
                        if (r_idx < 3'd4) begin
                            r_idx <= r_idx + 3'd1;
                            case (r_idx)
                                3'd0:    r_xs[15:8] <= w_data;
                                3'd1:    r_xs[7:0]  <= w_data;
                                3'd2:    r_xe[15:8] <= w_data;
                                default: begin
                                    r_xe[7:0] <= w_data;
                                    if (win_bad(r_xs, {r_xe[15:8], w_data}, r_ys, r_ye, c_w, c_h)) begin
                                        window_err <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    RASET: begin
                        if (r_idx < 3'd4) begin
                            r_idx <= r_idx + 3'd1;
                            case (r_idx)
                                3'd0:    r_ys[15:8] <= w_data;
                                3'd1:    r_ys[7:0]  <= w_data;
                                3'd2:    r_ye[15:8] <= w_data;
                                default: begin
                                    r_ye[7:0] <= w_data;
                                    if (win_bad(r_xs, r_xe, r_ys, {r_ye[15:8], w_data}, c_w, c_h)) begin
                                        window_err <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                    RAMWR: begin
                        if (!r_phase) begin
                            r_hi    <= w_data;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (!w_win_bad) begin
                                pix_valid <= 1'b1;
                                pix_data  <= {r_hi, w_data};
                                pix_x     <= r_x[8:0];
                                pix_y     <= r_y[8:0];
                            end
                            // Cursor advances even when the pixel is suppressed.
                            if (r_x < r_xe) begin
                                r_x <= r_x + 16'd1;
                            end else if (r_y < r_ye) begin
                                r_x <= r_xs;
                                r_y <= r_y + 16'd1;
                            end else begin
                                r_x <= r_xs;
                                r_y <= r_ys;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
